keypad_scanner_4x4: RTL
=======================

Name: keypad_scanner_4x4

Overview:
- Consumes the single-cycle scan-enable pulse from the slow tick generator and drives the column lines of a 4x4 matrix keypad, one column at a time.
- Samples the row lines and debounces presses and releases over a configurable number of scan ticks.
- Emits a 4-bit key code with a one-cycle valid pulse per debounced press.
- Downstream consumers (key decoder and display logic) see only clean, single-shot key events.

Parameters:
- DEBOUNCE_TICKS, 4, consecutive scan ticks a press or release must be stable before it is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock (100 MHz board clock).
- rst  input  1  reset; asynchronous, active-high.
- scan_tick  input  1  single-cycle enable pulse from the tick generator; spacing of 4 clk cycles or more is required.
- row_in  input  4  raw keypad rows; active-low, pulled up, asynchronous to clk.
- col_out  output  4  column drive; active-low, exactly one bit low at all times.
- key_code  output  4  debounced key code = row_index*4 + col_index; holds its value until the next accepted press.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_held  output  1  high while the accepted key remains pressed (until the release is debounced).

Behaviour:
- Reset values (applied asynchronously on rst high):
  - col_out = 4'b1110 (col_idx = 0).
  - key_code = 0, key_valid = 0, key_held = 0.
  - State IDLE, all counters 0, row synchronizer flops = 4'b1111.
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized value (row_s).
- Everything other than the synchronizer and key_valid clear advances only on clk edges where scan_tick = 1.
  - On such an edge, row_s is evaluated against the column driven since the previous tick, so it has settled for a full tick period.
- Hit: any row_s bit low for the current column. Candidate row = lowest-index low bit; candidate code = {row[1:0], col_idx[1:0]}.
- State machine (transitions only on scan_tick):
  - IDLE:
    - No hit: col_idx <= col_idx + 1 (wraps 3 -> 0).
    - Hit: latch cand <= code, cnt <= 1, hold column. If DEBOUNCE_TICKS == 1, accept immediately (see accept below) and go PRESSED; otherwise go DEBOUNCE.
  - DEBOUNCE (column held):
    - Hit with code == cand: cnt <= cnt + 1. When cnt + 1 == DEBOUNCE_TICKS, accept and go PRESSED.
    - No hit, or a different code: cnt <= 0, col_idx <= col_idx + 1, go IDLE; no pulse.
  - Accept: key_code <= cand, key_valid <= 1 for exactly one clk, key_held <= 1.
  - PRESSED (column held, key_held = 1):
    - No hit: rcnt <= rcnt + 1. When rcnt + 1 == DEBOUNCE_TICKS: key_held <= 0, rcnt <= 0, col_idx <= col_idx + 1, go IDLE.
    - Any hit on the held column: rcnt <= 0.
- Latency: key_valid is high in the clk cycle after the scan_tick edge on which the DEBOUNCE_TICKS-th consecutive matching sample occurs. key_code updates on that same edge.
- key_valid clears on the next clk edge regardless of scan_tick.
- Exactly one key_valid per press, however long the key is held.
- Other keys pressed while in PRESSED are ignored (the column is held). A new press is only detected after the release is debounced.
- Ghosting and multi-key rollover are not handled. Multiple rows low in one column resolve to the lowest row index.
- Counters are sized ceil(log2(DEBOUNCE_TICKS+1)) bits and never wrap.
- rst mid-DEBOUNCE or mid-PRESSED aborts immediately: no key_valid, key_held drops, scanning restarts at column 0.
- No scan_tick: col_out, state and counters are frozen indefinitely.

Test Plan:
- Reset: assert rst asynchronously mid-DEBOUNCE -> without waiting for a clk edge, col_out = 4'b1110, key_valid = 0, key_held = 0, key_code = 0; after release, scanning resumes from column 0.
- Clean press (DEBOUNCE_TICKS = 4, tick every 10 clk): row_in = 4'b1011 whenever col_out = 4'b1101 -> key_code = 9, a single one-cycle key_valid after the 4th matching tick. Release: key_held falls 4 ticks after the rows return to 4'b1111, then columns resume cycling 1101 -> 1011 -> 0111 -> 1110.
- Bounce: hit for 2 ticks, miss for 1 tick, then hit for 4 ticks -> no pulse from the first burst; exactly one key_valid at the end of the 4-tick run.
- Priority: rows 0 and 3 low (row_in = 4'b0110) while col_out = 4'b1011 -> key_code = 2.
- Long hold: key held for 200 ticks -> exactly one key_valid, key_held = 1 throughout, col_out constant.
- DEBOUNCE_TICKS = 1: a single hit tick on row 3, col 3 -> key_code = 15, key_valid on the next clk; no scan_tick for 50 clk -> outputs unchanged.

Source files
------------

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: walks one active-low column per scan tick, debounces
// press and release over DEBOUNCE_TICKS ticks, and emits one key_valid pulse per press.
module keypad_scanner_4x4 #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } sample_t;

  logic [3:0]    row_m, row_s;
  state_t        state, state_nx;
  logic [1:0]    col_idx, col_idx_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [CW-1:0] rcnt, rcnt_nx, rcnt_inc;
  logic [3:0]    cand, cand_nx;
  logic [3:0]    code_nx;
  logic          valid_nx, held_nx;
  sample_t       smp;
  logic [1:0]    row_idx;

  // Rows are asynchronous to clk; two flops before anything looks at them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  always_comb begin
    col_out          = 4'hF;
    col_out[col_idx] = 1'b0;
  end

  // Lowest-index low row wins when several rows are pulled low on one column.
  always_comb begin
    row_idx = 2'd3;
    if      (!row_s[0]) row_idx = 2'd0;
    else if (!row_s[1]) row_idx = 2'd1;
    else if (!row_s[2]) row_idx = 2'd2;
    smp.hit  = ~&row_s;
    smp.code = {row_idx, col_idx};
  end

  assign cnt_inc  = cnt + 1'b1;
  assign rcnt_inc = rcnt + 1'b1;

  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    cnt_nx     = cnt;
    rcnt_nx    = rcnt;
    cand_nx    = cand;
    code_nx    = key_code;
    held_nx    = key_held;
    valid_nx   = 1'b0;
    if (scan_tick) begin
      case (state)
        IDLE: begin
          if (!smp.hit) begin
            col_idx_nx = col_idx + 2'd1;
          end else begin
            cand_nx = smp.code;
            cnt_nx  = CW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              code_nx  = smp.code;
              valid_nx = 1'b1;
              held_nx  = 1'b1;
              cnt_nx   = '0;
              rcnt_nx  = '0;
              state_nx = PRESSED;
            end else begin
              state_nx = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (smp.hit && smp.code == cand) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              code_nx  = cand;
              valid_nx = 1'b1;
              held_nx  = 1'b1;
              cnt_nx   = '0;
              rcnt_nx  = '0;
              state_nx = PRESSED;
            end
          end else begin
            // A bounce or a different row restarts scanning from the next column.
            cnt_nx     = '0;
            col_idx_nx = col_idx + 2'd1;
            state_nx   = IDLE;
          end
        end
        PRESSED: begin
          if (!smp.hit) begin
            rcnt_nx = rcnt_inc;
            if (rcnt_inc == CNT_DONE) begin
              held_nx    = 1'b0;
              rcnt_nx    = '0;
              col_idx_nx = col_idx + 2'd1;
              state_nx   = IDLE;
            end
          end else begin
            rcnt_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col_idx   <= 2'd0;
      cnt       <= '0;
      rcnt      <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      cnt       <= cnt_nx;
      rcnt      <= rcnt_nx;
      cand      <= cand_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

endmodule
